alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the ALU's operand and operation inputs.
- Takes a fetched RV32I instruction, its PC and register-file read data, and decodes them into an operation code, operand A and operand B.
- Registers the result with a valid/ready handshake and a 2-entry skid buffer, so ready paths are registered on both sides.
- Sits between fetch/register read and the ALU execute stage.

Parameters:
- SIZE, 32, datapath width of PC, register data and operands (must be at least 20).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  upstream holds a valid instruction.
- IN_READY  output  1  stage accepts input this cycle; registered.
- INSTRUCTION  input  32  raw RV32I instruction word.
- PC  input  SIZE  address of the instruction.
- RS1_DATA  input  SIZE  register-file read port 1.
- RS2_DATA  input  SIZE  register-file read port 2.
- FLUSH  input  1  discard all buffered and incoming entries.
- OUT_VALID  output  1  A, B, OPERATION and ILLEGAL are valid.
- OUT_READY  input  1  execute stage consumes the output.
- A  output  SIZE  ALU operand A.
- B  output  SIZE  ALU operand B.
- OPERATION  output  4  e_operations code for the ALU.
- ILLEGAL  output  1  instruction is not supported by the ALU.

Behaviour:
- Reset: OUT_VALID=0, IN_READY=1, A=0, B=0, OPERATION=ADD, ILLEGAL=0, both buffer entries empty. Reset asserted mid-transfer drops all entries, with no partial output.
- Accept when IN_VALID && IN_READY. Output transfer when OUT_VALID && OUT_READY.
- Latency: an accepted instruction appears on the outputs the next cycle if the main register is empty or is draining that same cycle.
- Skid buffer:
  - Main register drives the outputs. Skid register catches an accept that occurs while the main register is stalled.
  - IN_READY(next) = skid empty after this cycle's update.
  - When the main register drains, the skid entry (if any) moves to main; otherwise a new accept goes to main.
  - Order is preserved. No entry is ever overwritten or dropped except by FLUSH/RESET.
- Simultaneous accept and drain with skid empty: new entry goes to main, skid stays empty, throughput is 1/cycle.
- FLUSH:
  - Clears both entries next cycle and ignores any input accepted that cycle.
  - IN_READY=1 next cycle.
  - FLUSH overrides accept and drain.
- Decode (combinational on input; the registered copy is what gets output):
  - OP 0110011, funct7=0: funct3 000→ADD, 100→XOR, 110→OR, 111→AND, 010 (slt)→SLTU, 011 (sltu)→SLT. The ALU's SLTU code performs the signed compare and SLT the unsigned one. A=RS1_DATA, B=RS2_DATA.
  - OP with funct7=0100000, funct3=000 → SUB.
  - OP-IMM 0010011: same funct3 map (no SUB). A=RS1_DATA, B=sign-extended instr[31:20].
  - LOAD 0000011: ADD, A=RS1, B=sext(instr[31:20]).
  - STORE 0100011: ADD, A=RS1, B=sext({instr[31:25],instr[11:7]}).
  - LUI 0110111: LUI, A=0, B=zero-extended instr[31:12]. The ALU shifts B left by 12.
  - AUIPC 0010111: AUIPC, A=PC, B=zero-extended instr[31:12].
  - BRANCH 1100011: funct3 000→BEQ, 001→BNE. A=RS1, B=RS2.
  - Anything else, including shifts, other branch funct3 values and bad funct7: ILLEGAL=1, OPERATION=ADD, A=0, B=0. Illegal instructions still flow through the handshake like any other entry.
- Sign extension is from bit 31 of the instruction to SIZE bits. No arithmetic is performed in this block.

Decomposition:
- e_operations (4-bit enum: ADD, SUB, AND, OR, XOR, SLT, SLTU, LUI, AUIPC, BEQ, BNE) lives in the shared operation_type package. Import it; do not redefine it.
- Add opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_BRANCH) to the same package.
- One sub-module: alu_issue_decode, purely combinational (instruction, PC, RS1, RS2 → A, B, OPERATION, ILLEGAL).
- The skid buffer and handshake stay in alu_issue_stage.

Test Plan:
- Reset held 2 cycles, then released → OUT_VALID=0, IN_READY=1, OPERATION=ADD, A=B=0.
- addi x1,x2,-5 (0xFFB10093), RS1=10, OUT_READY=1 → next cycle OUT_VALID=1, OPERATION=ADD, A=10, B=0xFFFFFFFB.
- lui 0x12345 (0x123450B7) then auipc 0x1 (0x00001097) with PC=0x100, back-to-back → LUI with A=0, B=0x12345; then AUIPC with A=0x100, B=0x1. One per cycle.
- Stream 4 instructions with OUT_READY low for 3 cycles:
  - IN_READY drops after 2 accepts.
  - Outputs hold stable while stalled.
  - After OUT_READY rises, all 4 emerge in order with no loss or duplication.
- Skid full, FLUSH=1 together with IN_VALID=1 → next cycle OUT_VALID=0, IN_READY=1, and the flushed instruction never appears.
- sll x1,x2,x3 (0x003110B3) → ILLEGAL=1, OPERATION=ADD, A=B=0. bne (funct3 001) → BNE. slt → SLTU code.

Source files
------------

// File: rtl/operation_type_pkg.sv
// operation_type: shared ALU definitions for the issue and execute stages.
//   e_operations  - 4-bit ALU operation code driven by the issue stage.
//   OPC_*         - RV32I major opcodes recognised by the issue decoder.
//   funct3_legal / funct3_op - register/immediate ALU funct3 mapping.
package operation_type;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        SLT   = 4'd5,
        SLTU  = 4'd6,
        LUI   = 4'd7,
        AUIPC = 4'd8,
        BEQ   = 4'd9,
        BNE   = 4'd10
    } e_operations;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Shifts (001, 101) are not handled by this ALU.
    function automatic logic funct3_legal(input logic [2:0] funct3);
        return (funct3 != 3'b001) && (funct3 != 3'b101);
    endfunction

    // The ALU's SLTU code does the signed compare and SLT the unsigned
    // one, so slt/sltu are deliberately crossed here.
    function automatic e_operations funct3_op(input logic [2:0] funct3);
        case (funct3)
            3'b100:  return XOR;
            3'b110:  return OR;
            3'b111:  return AND;
            3'b010:  return SLTU;
            3'b011:  return SLT;
            default: return ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I decoder producing ALU inputs.
//   instruction - raw instruction word
//   pc          - address of the instruction
//   rs1_data    - register-file read port 1
//   rs2_data    - register-file read port 2
//   a, b        - ALU operands (both zero for unsupported instructions)
//   operation   - ALU operation code (ADD for unsupported instructions)
//   illegal     - instruction is not supported by the ALU
module alu_issue_decode
    import operation_type::*;
#(
    parameter int SIZE = 32
) (
    input  logic [31:0]     instruction,
    input  logic [SIZE-1:0] pc,
    input  logic [SIZE-1:0] rs1_data,
    input  logic [SIZE-1:0] rs2_data,
    output logic [SIZE-1:0] a,
    output logic [SIZE-1:0] b,
    output e_operations     operation,
    output logic            illegal
);

    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [SIZE-1:0] imm_i;
    logic [SIZE-1:0] imm_s;
    logic [SIZE-1:0] imm_u;

    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign imm_i  = SIZE'($signed(instruction[31:20]));
    assign imm_s  = SIZE'($signed({instruction[31:25], instruction[11:7]}));
    // Upper immediate is passed unshifted; the ALU applies the << 12.
    assign imm_u  = SIZE'(instruction[31:12]);

    always_comb begin
        a         = '0;
        b         = '0;
        operation = ADD;
        illegal   = 1'b0;
        case (instruction[6:0])
            OPC_OP: begin
                if (funct7 == 7'b0000000 && funct3_legal(funct3)) begin
                    operation = funct3_op(funct3);
                    a         = rs1_data;
                    b         = rs2_data;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    operation = SUB;
                    a         = rs1_data;
                    b         = rs2_data;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (funct3_legal(funct3)) begin
                    operation = funct3_op(funct3);
                    a         = rs1_data;
                    b         = imm_i;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                a = rs1_data;
                b = imm_i;
            end
            OPC_STORE: begin
                a = rs1_data;
                b = imm_s;
            end
            OPC_LUI: begin
                operation = LUI;
                b         = imm_u;
            end
            OPC_AUIPC: begin
                operation = AUIPC;
                a         = pc;
                b         = imm_u;
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    operation = (funct3 == 3'b000) ? BEQ : BNE;
                    a         = rs1_data;
                    b         = rs2_data;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage feeding the ALU, with a registered
// valid/ready handshake on both sides built from a 2-entry skid buffer.
//   CLK, RESET            - clock, synchronous active-high reset
//   IN_VALID / IN_READY   - upstream handshake (IN_READY is a flop)
//   INSTRUCTION, PC       - fetched instruction and its address
//   RS1_DATA, RS2_DATA    - register-file read data
//   FLUSH                 - drop buffered and incoming entries
//   OUT_VALID / OUT_READY - downstream handshake
//   A, B, OPERATION       - ALU operands and operation code
//   ILLEGAL               - instruction not supported by the ALU
module alu_issue_stage
    import operation_type::*;
#(
    parameter int SIZE = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     INSTRUCTION,
    input  logic [SIZE-1:0] PC,
    input  logic [SIZE-1:0] RS1_DATA,
    input  logic [SIZE-1:0] RS2_DATA,
    input  logic            FLUSH,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SIZE-1:0] A,
    output logic [SIZE-1:0] B,
    output logic [3:0]      OPERATION,
    output logic            ILLEGAL
);

    typedef struct packed {
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        e_operations     op;
        logic            ill;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{a: '0, b: '0, op: ADD, ill: 1'b0};

    entry_t dec_entry;
    entry_t main_reg;
    entry_t skid_reg;
    logic   main_valid_reg;
    logic   skid_valid_reg;
    logic   in_ready_reg;
    logic   accept;
    logic   main_free;

    alu_issue_decode #(.SIZE(SIZE)) u_decode (
        .instruction (INSTRUCTION),
        .pc          (PC),
        .rs1_data    (RS1_DATA),
        .rs2_data    (RS2_DATA),
        .a           (dec_entry.a),
        .b           (dec_entry.b),
        .operation   (dec_entry.op),
        .illegal     (dec_entry.ill)
    );

    assign accept    = IN_VALID && in_ready_reg;
    // Main can take a new entry when it is empty or being consumed now.
    assign main_free = !main_valid_reg || OUT_READY;

    // IN_READY is low exactly while the skid holds an entry, so an accept
    // never coincides with a skid->main move and nothing is overwritten.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_reg       <= ENTRY_RESET;
            skid_reg       <= ENTRY_RESET;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else if (FLUSH) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else if (main_free) begin
            in_ready_reg <= 1'b1;
            if (skid_valid_reg) begin
                main_reg       <= skid_reg;
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                main_reg       <= dec_entry;
                main_valid_reg <= 1'b1;
            end else begin
                main_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            skid_reg       <= dec_entry;
            skid_valid_reg <= 1'b1;
            in_ready_reg   <= 1'b0;
        end
    end

    assign IN_READY  = in_ready_reg;
    assign OUT_VALID = main_valid_reg;
    assign A         = main_reg.a;
    assign B         = main_reg.b;
    assign OPERATION = main_reg.op;
    assign ILLEGAL   = main_reg.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios plus randomized traffic,
// checked through a scoreboard queue fed by an independent decode model.
module tb_alu_issue_stage;
    import operation_type::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  operation;
    logic        illegal;

    int checks = 0;
    int passes = 0;

    // {illegal, operation, a, b}
    logic [68:0] sb_q[$];
    logic [68:0] prev_out;
    logic        prev_hold = 1'b0;

    alu_issue_stage #(.SIZE(32)) dut (
        .CLK         (clk),
        .RESET       (reset),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready),
        .INSTRUCTION (instruction),
        .PC          (pc),
        .RS1_DATA    (rs1_data),
        .RS2_DATA    (rs2_data),
        .FLUSH       (flush),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .A           (a),
        .B           (b),
        .OPERATION   (operation),
        .ILLEGAL     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Reference decode, written straight from the instruction-set rules.
    function automatic logic [68:0] model(input logic [31:0] ins, input logic [31:0] p,
                                          input logic [31:0] r1, input logic [31:0] r2);
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          imm_i;
        int          imm_s;
        logic [31:0] imm_u;
        e_operations alu_op;
        logic        alu_ok;
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = $signed(ins[31:20]);
        imm_s = $signed({ins[31:25], ins[11:7]});
        imm_u = ins[31:12];
        alu_ok = 1'b1;
        case (f3)
            3'd0: alu_op = ADD;
            3'd2: alu_op = SLTU;   // slt uses the ALU's SLTU code
            3'd3: alu_op = SLT;    // sltu uses the ALU's SLT code
            3'd4: alu_op = XOR;
            3'd6: alu_op = OR;
            3'd7: alu_op = AND;
            default: begin alu_op = ADD; alu_ok = 1'b0; end
        endcase
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00 && alu_ok) return {1'b0, alu_op, r1, r2};
                if (f7 == 7'h20 && f3 == 3'd0) return {1'b0, SUB, r1, r2};
            end
            7'h13: if (alu_ok) return {1'b0, alu_op, r1, 32'(imm_i)};
            7'h03: return {1'b0, ADD, r1, 32'(imm_i)};
            7'h23: return {1'b0, ADD, r1, 32'(imm_s)};
            7'h37: return {1'b0, LUI, 32'd0, imm_u};
            7'h17: return {1'b0, AUIPC, p, imm_u};
            7'h63: begin
                if (f3 == 3'd0) return {1'b0, BEQ, r1, r2};
                if (f3 == 3'd1) return {1'b0, BNE, r1, r2};
            end
            default: ;
        endcase
        return {1'b1, ADD, 32'd0, 32'd0};
    endfunction

    // Input side: every accept pushes its expected result; flush and reset
    // discard everything in flight including this cycle's input.
    always @(negedge clk) begin
        if (reset || flush) sb_q.delete();
        else if (in_valid && in_ready) sb_q.push_back(model(instruction, pc, rs1_data, rs2_data));
    end

    // Output side: pop and compare on every transfer; outputs must stay
    // frozen while stalled.
    always @(negedge clk) begin
        logic [68:0] cur;
        cur = {illegal, operation, a, b};
        if (prev_hold && out_valid && !reset)
            check("stall_stable", cur, prev_out);
        if (!reset && !flush && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got %h, required no output", cur);
            end else begin
                check("scoreboard", cur, sb_q.pop_front());
            end
        end
        prev_hold = out_valid && !out_ready && !flush && !reset;
        prev_out  = cur;
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2);
        bit done = 0;
        in_valid = 1'b1; instruction = ins; pc = p; rs1_data = r1; rs2_data = r2;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
        end
        if (!done) begin
            checks++;
            $display("FAIL send_timeout: got IN_READY=0 for 50 cycles, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", 69'(sb_q.size()), 69'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opcs[8];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h00};
        ins = $urandom;
        ins[6:0] = opcs[$urandom_range(0, 7)];
        if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
        case ($urandom_range(0, 3))
            0, 1: ins[31:25] = 7'h00;
            2:    ins[31:25] = 7'h20;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; instruction = '0; pc = '0;
        rs1_data = '0; rs2_data = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_state", {out_valid, in_ready, illegal, operation, a, b},
              {1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0});

        // addi x1,x2,-5
        send(32'hFFB10093, 32'h0, 32'd10, 32'd0);
        check("addi_latency", {out_valid, illegal, operation, a, b},
              {1'b1, 1'b0, 4'd0, 32'd10, 32'hFFFF_FFFB});

        // lui then auipc back-to-back, one per cycle
        send(32'h123450B7, 32'h100, 32'h5, 32'h6);
        check("lui_out", {out_valid, operation, a, b}, {1'b1, 4'd7, 32'd0, 32'h12345});
        send(32'h00001097, 32'h100, 32'h5, 32'h6);
        check("auipc_out", {out_valid, operation, a, b}, {1'b1, 4'd8, 32'h100, 32'h1});
        drain();

        // four instructions against a 3-cycle stall
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd1, 32'd2);   // add
        send(32'h402081B3, 32'h0, 32'd3, 32'd4);   // sub
        check("in_ready_drop", 69'(in_ready), 69'd0);
        fork
            begin
                send(32'h0020C1B3, 32'h0, 32'd5, 32'd6);   // xor
                send(32'h0020F1B3, 32'h0, 32'd7, 32'd8);   // and
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // flush with the skid full and a new instruction offered
        out_ready = 1'b0;
        send(32'h0020E1B3, 32'h0, 32'd9, 32'd10);  // or
        send(32'h0020A1B3, 32'h0, 32'd11, 32'd12); // slt
        in_valid = 1'b1; instruction = 32'h00A00093; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_state", {out_valid, in_ready}, {1'b0, 1'b1});
        drain();

        // reset while entries are buffered
        out_ready = 1'b0;
        send(32'h0020B1B3, 32'h0, 32'd13, 32'd14); // sltu
        send(32'h00209463, 32'h0, 32'd15, 32'd16); // bne
        reset = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        check("midreset_state", {out_valid, in_ready, illegal, operation, a, b},
              {1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0});
        drain();

        // illegal shift, bne, slt
        send(32'h003110B3, 32'h0, 32'd3, 32'd4);
        check("sll_illegal", {illegal, operation, a, b}, {1'b1, 4'd0, 32'd0, 32'd0});
        send(32'h00209463, 32'h0, 32'd21, 32'd22);
        check("bne_op", 69'(operation), 69'(BNE));
        send(32'h0020A0B3, 32'h0, 32'd23, 32'd24);
        check("slt_op", 69'(operation), 69'(SLTU));
        drain();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            instruction = rand_instr();
            pc          = $urandom;
            rs1_data    = $urandom;
            rs2_data    = $urandom;
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
